marquee_scroller: RTL

Sequences a scrolling text marquee across the six 7-segment displays HEX5..HEX0, for example "PAYSANDU" moving right-to-left.
- Holds a writable message buffer of character codes.
- Steps a window offset at a prescaled rate.
- Pauses briefly at each wrap.
- Decodes the six visible characters to active-low segment patterns.

It replaces the free-running counter-plus-offset arrangement in the top level with a controlled sequencer.

---
 rtl/marquee_scroller_pkg.sv | 70 +++++++
 rtl/marquee_scroller_if.sv | 39 +++
 rtl/marquee_scroller_char7seg.sv | 26 ++
 rtl/marquee_scroller.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/marquee_scroller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | marquee_pkg: character codes, states and 7-segment font        |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package marquee_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [4:0] CH_A     = 5'd10;
    localparam logic [4:0] CH_B     = 5'd11;
    localparam logic [4:0] CH_C     = 5'd12;
    localparam logic [4:0] CH_D     = 5'd13;
    localparam logic [4:0] CH_E     = 5'd14;
    localparam logic [4:0] CH_F     = 5'd15;
    localparam logic [4:0] CH_H     = 5'd16;
    localparam logic [4:0] CH_L     = 5'd17;
    localparam logic [4:0] CH_N     = 5'd18;
    localparam logic [4:0] CH_O     = 5'd19;
    localparam logic [4:0] CH_P     = 5'd20;
    localparam logic [4:0] CH_R     = 5'd21;
    localparam logic [4:0] CH_U     = 5'd22;
    localparam logic [4:0] CH_Y     = 5'd23;
    localparam logic [4:0] CH_DASH  = 5'd24;
    localparam logic [4:0] CH_BLANK = 5'd31;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Active-low segments, bit0 = a ... bit6 = g
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'h40;
            5'd1:    seg = 7'h79;
            5'd2:    seg = 7'h24;
            5'd3:    seg = 7'h30;
            5'd4:    seg = 7'h19;
            5'd5:    seg = 7'h12;
            5'd6:    seg = 7'h02;
            5'd7:    seg = 7'h78;
            5'd8:    seg = 7'h00;
            5'd9:    seg = 7'h10;
            CH_A:    seg = 7'h08;
            CH_B:    seg = 7'h03;
            CH_C:    seg = 7'h46;
            CH_D:    seg = 7'h21;
            CH_E:    seg = 7'h06;
            CH_F:    seg = 7'h0E;
            CH_H:    seg = 7'h09;
            CH_L:    seg = 7'h47;
            CH_N:    seg = 7'h2B;
            CH_O:    seg = 7'h23;
            CH_P:    seg = 7'h0C;
            CH_R:    seg = 7'h2F;
            CH_U:    seg = 7'h41;
            CH_Y:    seg = 7'h11;
            CH_DASH: seg = 7'h3F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/marquee_scroller_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | marquee_scroller_if: write port, commands and display outputs  |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
interface marquee_scroller_if #(
    parameter int MSG_MAX = 16,
    parameter int CW      = 5
);
    localparam int AW = $clog2(MSG_MAX);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic [AW:0]   msg_len;
    logic          start;
    logic          stop;
    logic          dir;
    logic          busy;
    logic          wrap;
    logic [6:0]    HEX5;
    logic [6:0]    HEX4;
    logic [6:0]    HEX3;
    logic [6:0]    HEX2;
    logic [6:0]    HEX1;
    logic [6:0]    HEX0;

    modport master (
        output wr_en, wr_addr, wr_data, msg_len, start, stop, dir,
        input  busy, wrap, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, msg_len, start, stop, dir,
        output busy, wrap, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0
    );

endinterface
`default_nettype wire

// File: rtl/marquee_scroller_char7seg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | char7seg: character code to active-low 7-segment pattern       |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module char7seg
    import marquee_pkg::*;
#(
    parameter int CW = 5
) (
    input  wire logic [CW-1:0] code_i,
    output logic      [6:0]    seg_o
);
    logic [31:0] w_code_ext;

    // Codes outside the 5-bit font range render as blank
    always_comb begin
        w_code_ext = 32'(code_i);
        seg_o      = SEG_BLANK;
        if (w_code_ext < 32'd32) begin
            seg_o = seg_decode(w_code_ext[4:0]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/marquee_scroller.sv
`default_nettype none
// +----------------------------------------------------------------+
// | marquee_scroller: message buffer, scroll sequencer, 6 digits   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module marquee_scroller
    import marquee_pkg::*;
#(
    parameter int MSG_MAX     = 16,
    parameter int TICK_DIV    = 12500000,
    parameter int PAUSE_TICKS = 4,
    parameter int CW          = 5
) (
    input  wire logic         CLOCK50,
    input  wire logic         reset,
    marquee_scroller_if.slave bus
);
    localparam int AW = $clog2(MSG_MAX);
    localparam int LW = AW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = (PAUSE_TICKS > 0) ? HW'(PAUSE_TICKS - 1) : '0;
    localparam logic [LW-1:0] LEN_MAX   = LW'(MSG_MAX);

    state_t        state_q, state_d;
    logic [AW-1:0] pos_q,   pos_d;
    logic [LW-1:0] len_q,   len_d;
    logic [PW-1:0] pre_q,   pre_d;
    logic [HW-1:0] hold_q,  hold_d;
    logic [CW-1:0] msg_q [MSG_MAX];
    logic [6:0]    hex_q [NUM_DIGITS];

    logic          w_busy;
    logic          w_tick;
    logic          w_step_wrap;
    logic          w_wrap;
    logic [LW-1:0] w_len_in;
    logic [AW-1:0] w_idx [NUM_DIGITS];
    logic [6:0]    w_seg [NUM_DIGITS];

    assign w_busy      = (state_q != ST_IDLE);
    assign w_tick      = w_busy && (pre_q == PRE_LAST);
    assign w_step_wrap = bus.dir ? (pos_q == '0) : (LW'(pos_q) == (len_q - LW'(1)));

    always_comb begin
        w_len_in = bus.msg_len;
        if (bus.msg_len == '0) begin
            w_len_in = LW'(1);
        end else if (bus.msg_len > LEN_MAX) begin
            w_len_in = LEN_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        len_d   = len_q;
        pre_d   = pre_q;
        hold_d  = hold_q;
        w_wrap  = 1'b0;
        if (w_busy) begin
            pre_d = w_tick ? '0 : pre_q + PW'(1);
        end
        // stop outranks start; start while busy falls through as a no-op
        if (w_busy && bus.stop) begin
            state_d = ST_IDLE;
            pre_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = ST_SCROLL;
                        len_d   = w_len_in;
                        pre_d   = '0;
                        hold_d  = '0;
                        if (LW'(pos_q) >= w_len_in) begin
                            pos_d = '0;
                        end
                    end
                end
                ST_SCROLL: begin
                    if (w_tick) begin
                        if (w_step_wrap) begin
                            w_wrap = 1'b1;
                            pos_d  = bus.dir ? AW'(len_q - LW'(1)) : '0;
                            if (PAUSE_TICKS > 0) begin
                                state_d = ST_HOLD;
                                hold_d  = '0;
                            end
                        end else begin
                            pos_d = bus.dir ? pos_q - AW'(1) : pos_q + AW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = ST_SCROLL;
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Walk the window one digit at a time so no divider is needed for the modulo
    always_comb begin
        w_idx[0] = pos_q;
        for (int d = 1; d < NUM_DIGITS; d++) begin
            w_idx[d] = ((LW'(w_idx[d-1]) + LW'(1)) == len_q) ? '0 : w_idx[d-1] + AW'(1);
        end
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        char7seg #(.CW(CW)) u_seg (
            .code_i (msg_q[w_idx[d]]),
            .seg_o  (w_seg[d])
        );
    end

    always_ff @(posedge CLOCK50) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            len_q   <= LW'(1);
            pre_q   <= '0;
            hold_q  <= '0;
            for (int i = 0; i < MSG_MAX; i++) begin
                msg_q[i] <= CW'(CH_BLANK);
            end
            for (int d = 0; d < NUM_DIGITS; d++) begin
                hex_q[d] <= SEG_BLANK;
            end
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            pre_q   <= pre_d;
            hold_q  <= hold_d;
            if (bus.wr_en) begin
                msg_q[bus.wr_addr] <= bus.wr_data;
            end
            for (int d = 0; d < NUM_DIGITS; d++) begin
                hex_q[d] <= w_seg[d];
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.wrap = w_wrap;
    assign bus.HEX5 = hex_q[0];
    assign bus.HEX4 = hex_q[1];
    assign bus.HEX3 = hex_q[2];
    assign bus.HEX2 = hex_q[3];
    assign bus.HEX1 = hex_q[4];
    assign bus.HEX0 = hex_q[5];

endmodule
`default_nettype wire
